// File: rtl/alu_uart_ctrl_if.sv
// alu_uart_ctrl_if
//   Bundles the UART byte streams and the ALU entry/result bus seen by
//   alu_uart_ctrl.
//   master : controller side (drives ALU entry bus and transmit request).
//   slave  : environment side (UART receiver/transmitter and ALU).
//   Signals: rx_data/rx_valid (received byte), alu_bus/alu_enables (ALU load),
//            alu_result/alu_carry/alu_done (ALU result), tx_data/tx_start/
//            tx_busy (transmitter handshake).
interface alu_uart_ctrl_if #(
  parameter int DATA_BUS = 8
);
  logic [DATA_BUS-1:0] rx_data;
  logic                rx_valid;
  logic [DATA_BUS-1:0] alu_bus;
  logic [2:0]          alu_enables;
  logic [DATA_BUS-1:0] alu_result;
  logic                alu_carry;
  logic                alu_done;
  logic [DATA_BUS-1:0] tx_data;
  logic                tx_start;
  logic                tx_busy;

  modport master (
    input  rx_data, rx_valid, alu_result, alu_carry, alu_done, tx_busy,
    output alu_bus, alu_enables, tx_data, tx_start
  );

  modport slave (
    output rx_data, rx_valid, alu_result, alu_carry, alu_done, tx_busy,
    input  alu_bus, alu_enables, tx_data, tx_start
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl
//   Sequencer between a UART byte receiver/transmitter and an 8-bit ALU.
//   Collects operand A, operand B and opcode bytes, strobes them into the
//   ALU over its shared entry bus, waits for the result (or a timeout) and
//   sends the result byte back through the transmitter.
//
//   Optional feature macro: CARRY_TX_EN -- when defined a second byte holding
//   the captured carry is sent after the result byte.
//
//   Ports:
//     clk          system clock, rising edge
//     reset_n      synchronous active-low reset
//     bus          alu_uart_ctrl_if.master (UART + ALU signals)
//     busy         high whenever not waiting for operand A
//     overrun      sticky: a received byte was dropped
//     timeout_flag last transaction's result was taken without alu_done
module alu_uart_ctrl #(
  parameter int DATA_BUS    = 8,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_uart_ctrl_if.master   bus,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_flag
);

  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    GET_OP,
    LD_A,
    LD_B,
    LD_OP,
    EVAL,
    WAIT,
    TX_RES,
`ifdef CARRY_TX_EN
    TX_CARRY,
    TX_HOLD2,
`endif
    TX_HOLD
  } state_t;

  state_t              state;
  logic [DATA_BUS-1:0] byte_a, byte_b, byte_op;
  logic [DATA_BUS-1:0] res_q;
  logic [CW-1:0]       wait_cnt;
  logic                hold_skip;
  logic                tx_start_q;
  logic                overrun_q;
  logic                timeout_q;
`ifdef CARRY_TX_EN
  logic                carry_q;
`else
  // Carry is not part of the single-byte reply.
  logic                unused_carry;
  assign unused_carry = bus.alu_carry;
`endif

  logic in_get;
  assign in_get = (state == GET_A) || (state == GET_B) || (state == GET_OP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= GET_A;
      byte_a     <= '0;
      byte_b     <= '0;
      byte_op    <= '0;
      res_q      <= '0;
      wait_cnt   <= '0;
      hold_skip  <= 1'b0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef CARRY_TX_EN
      carry_q    <= 1'b0;
`endif
    end else begin
      // tx_start is a single-cycle pulse unless re-armed below.
      tx_start_q <= 1'b0;

      if (bus.rx_valid && !in_get)
        overrun_q <= 1'b1;

      case (state)
        GET_A: if (bus.rx_valid) begin
          byte_a    <= bus.rx_data;
          timeout_q <= 1'b0;
          state     <= GET_B;
        end
        GET_B: if (bus.rx_valid) begin
          byte_b <= bus.rx_data;
          state  <= GET_OP;
        end
        GET_OP: if (bus.rx_valid) begin
          byte_op <= bus.rx_data;
          state   <= LD_A;
        end
        LD_A:  state <= LD_B;
        LD_B:  state <= LD_OP;
        LD_OP: state <= EVAL;
        EVAL: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // alu_done wins over the timeout on the last cycle. The ALU only
          // pulses done on a changed result, so a repeated result arrives
          // here via the timeout with the (unchanged) result still valid.
          if (bus.alu_done || wait_cnt == WAIT_LAST) begin
            res_q <= bus.alu_result;
`ifdef CARRY_TX_EN
            carry_q <= bus.alu_carry;
`endif
            if (!bus.alu_done)
              timeout_q <= 1'b1;
            // Pulse immediately on entry if the transmitter is already idle.
            tx_start_q <= !bus.tx_busy;
            state      <= TX_RES;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        TX_RES: begin
          if (tx_start_q) begin
            hold_skip <= 1'b1;
            state     <= TX_HOLD;
          end else if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
          end
        end
        TX_HOLD: begin
          // Transmitter may not have raised busy yet in the first cycle.
          if (hold_skip) begin
            hold_skip <= 1'b0;
          end else if (!bus.tx_busy) begin
`ifdef CARRY_TX_EN
            tx_start_q <= 1'b1;
            state      <= TX_CARRY;
`else
            state <= GET_A;
`endif
          end
        end
`ifdef CARRY_TX_EN
        TX_CARRY: begin
          if (tx_start_q) begin
            hold_skip <= 1'b1;
            state     <= TX_HOLD2;
          end else if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
          end
        end
        TX_HOLD2: begin
          if (hold_skip) begin
            hold_skip <= 1'b0;
          end else if (!bus.tx_busy) begin
            state <= GET_A;
          end
        end
`endif
        default: state <= GET_A;
      endcase
    end
  end

  // Output decode: registered state/data only, no input-to-output path.
  always_comb begin
    bus.alu_bus     = '0;
    bus.alu_enables = 3'b000;
    bus.tx_data     = '0;
    case (state)
      LD_A: begin
        bus.alu_bus     = byte_a;
        bus.alu_enables = 3'b001;
      end
      LD_B: begin
        bus.alu_bus     = byte_b;
        bus.alu_enables = 3'b010;
      end
      // Opcode strobe held two cycles: first edge latches, second computes.
      LD_OP, EVAL: begin
        bus.alu_bus     = byte_op;
        bus.alu_enables = 3'b100;
      end
      TX_RES: bus.tx_data = res_q;
`ifdef CARRY_TX_EN
      TX_CARRY: bus.tx_data = {{(DATA_BUS-1){1'b0}}, carry_q};
`endif
      default: ;
    endcase
  end

  assign bus.tx_start  = tx_start_q;
  assign busy          = (state != GET_A);
  assign overrun       = overrun_q;
  assign timeout_flag  = timeout_q;

endmodule
